dma_chunk_scheduler: RTL and testbench
======================================

DMA_CHUNK_SCHEDULER -- requirements
Module: dma_chunk_scheduler

Interface
REQ-001 Parameter g_CHANNELS, default 2: number of requesting channels, range 1..8.
REQ-002 Parameter g_MAX_CHUNK, default 4096: maximum chunk size and host boundary alignment in bytes, a power of 2 from 64 to 4096.
REQ-003 Parameter g_TIMEOUT, default 125000: maximum clk_i cycles allowed between chunk acceptance and done_i, range 1..2^24.
REQ-004 clk_i  in  1  the single system clock; all logic is rising-edge.
REQ-005 rst_i  in  1  asynchronous, active-high reset.
REQ-006 req_valid_i  in  g_CHANNELS  per-channel job request.
REQ-007 req_ready_o  out  g_CHANNELS  per-channel job accept; one-cycle pulse.
REQ-008 req_host_addr_i  in  64*g_CHANNELS  job host byte address, flattened with channel 0 at the LSBs.
REQ-009 req_dev_addr_i  in  32*g_CHANNELS  job device byte address.
REQ-010 req_len_i  in  32*g_CHANNELS  job length in bytes.
REQ-011 req_dir_i  in  g_CHANNELS  0 = device-to-host read, 1 = host-to-device write.
REQ-012 cmd_valid_o / cmd_ready_i  out/in  1/1  chunk command handshake.
REQ-013 cmd_host_addr_o 64, cmd_dev_addr_o 32, cmd_len_o 32, cmd_dir_o 1, cmd_last_o 1, cmd_ch_o 3  out  chunk fields.
REQ-014 done_i / err_i  in  1/1  engine chunk completion pulse / chunk error pulse.
REQ-015 job_done_o / job_err_o  out  g_CHANNELS  per-channel one-cycle job completion / job failure pulse.
REQ-016 busy_o  out  1  high whenever the state is not IDLE.

Function
REQ-017 The block SHALL have four states: IDLE, ISSUE, WAIT, FINISH.
REQ-018 IDLE, any req_valid_i set: the block SHALL round-robin grant the lowest channel index above the last granted channel, wrapping; the first grant after reset goes to channel 0.
REQ-019 On grant the block SHALL pulse req_ready_o for the granted channel, latch addresses/length/direction in the same cycle, then enter ISSUE.
REQ-020 A granted job with req_len_i = 0 SHALL go straight to FINISH, issue no command, and pulse job_done_o.
REQ-021 Chunk length SHALL be min(remaining, g_MAX_CHUNK - (host_addr mod g_MAX_CHUNK)), so no chunk crosses a g_MAX_CHUNK host boundary.
REQ-022 ISSUE: cmd_valid_o SHALL be high, all cmd_* fields SHALL stay stable until cmd_ready_i, and cmd_last_o SHALL be high when chunk length equals remaining.
REQ-023 On the cmd_valid_o and cmd_ready_i cycle the block SHALL advance host_addr and dev_addr by the chunk length, subtract it from remaining, clear the timeout counter, and enter WAIT.
REQ-024 WAIT, done_i: go to ISSUE if remaining > 0, else FINISH.
REQ-025 WAIT, err_i, or the timeout counter reaching g_TIMEOUT: go to FINISH with the error flag set; err_i SHALL win if it coincides with done_i.
REQ-026 FINISH SHALL last one cycle, pulse job_done_o or job_err_o for the owning channel, and return to IDLE; arbitration SHALL resume the next cycle.
REQ-027 done_i or err_i outside WAIT SHALL be ignored.
REQ-028 Address arithmetic SHALL wrap modulo 2^64 (host) and 2^32 (device) with no error.
REQ-029 No request SHALL be granted while a job is in progress, and req_valid_i deassertion after grant SHALL not affect that job.

Reset
REQ-030 While rst_i is high: state IDLE, round-robin pointer set so channel 0 wins next, all counters 0, and every output 0 (cmd_valid_o, req_ready_o, job_done_o, job_err_o, busy_o, all cmd_* fields).
REQ-031 An rst_i assertion mid-job SHALL abandon the job immediately and SHALL produce no job_done_o/job_err_o pulse.

Verification
REQ-032 Scenario: ch0 job, host 0x2000_0000, dev 0x100, len 10000, g_MAX_CHUNK=4096, done_i 5 cycles after each accept -> chunks 4096/4096/1808, dev 0x100/0x1100/0x2100, cmd_last_o only on the third, one job_done_o[0].
REQ-033 Scenario: host 0x2000_0F00, len 512 -> chunks 256 then 256 at host 0x2000_1000.
REQ-034 Scenario: ch0 and ch1 request together and hold req_valid_i -> grants alternate 0,1,0,1 and cmd_ch_o matches each grant.
REQ-035 Scenario: g_TIMEOUT=100, done_i never arrives -> job_err_o pulses 100 cycles after the chunk was accepted, busy_o then drops.
REQ-036 Scenario: cmd_ready_i held low for 20 cycles -> cmd_* fields stay stable throughout; rst_i asserted in WAIT -> all outputs go to 0 with no job pulse.
REQ-037 Scenario: len 0 on ch1 -> no cmd_valid_o, and job_done_o[1] pulses 2 cycles after the grant.

Source files
------------

// File: rtl/dma_chunk_scheduler.sv
// Splits per-channel DMA jobs into host-boundary-aligned chunk commands,
// arbitrating round-robin between channels and tracking completion/timeouts.
module dma_chunk_scheduler #(
    parameter int g_CHANNELS  = 2,
    parameter int g_MAX_CHUNK = 4096,
    parameter int g_TIMEOUT   = 125000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [g_CHANNELS-1:0]    req_valid_i,
    output logic [g_CHANNELS-1:0]    req_ready_o,
    input  logic [64*g_CHANNELS-1:0] req_host_addr_i,
    input  logic [32*g_CHANNELS-1:0] req_dev_addr_i,
    input  logic [32*g_CHANNELS-1:0] req_len_i,
    input  logic [g_CHANNELS-1:0]    req_dir_i,
    output logic                     cmd_valid_o,
    input  logic                     cmd_ready_i,
    output logic [63:0]              cmd_host_addr_o,
    output logic [31:0]              cmd_dev_addr_o,
    output logic [31:0]              cmd_len_o,
    output logic                     cmd_dir_o,
    output logic                     cmd_last_o,
    output logic [2:0]               cmd_ch_o,
    input  logic                     done_i,
    input  logic                     err_i,
    output logic [g_CHANNELS-1:0]    job_done_o,
    output logic [g_CHANNELS-1:0]    job_err_o,
    output logic                     busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

    state_t      r_state, w_next;
    logic [63:0] r_host;
    logic [31:0] r_dev, r_rem;
    logic        r_dir, r_err;
    logic [2:0]  r_ch, r_last;
    logic [24:0] r_timer;

    logic        w_grant_any;
    logic [2:0]  w_grant_ch;
    logic [31:0] w_offset, w_span, w_chunk;
    logic        w_accept, w_timeout;

    // Scan from farthest to nearest so the channel right after r_last wins.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_ch  = '0;
        for (int off = g_CHANNELS; off >= 1; off--) begin
            for (int i = 0; i < g_CHANNELS; i++) begin
                if ((i == (int'(r_last) + off) % g_CHANNELS) && req_valid_i[i]) begin
                    w_grant_any = 1'b1;
                    w_grant_ch  = 3'(i);
                end
            end
        end
    end

    assign w_offset  = 32'(r_host & 64'(g_MAX_CHUNK - 1));
    assign w_span    = 32'(g_MAX_CHUNK) - w_offset;
    assign w_chunk   = (r_rem < w_span) ? r_rem : w_span;
    assign w_accept  = (r_state == S_ISSUE) && (r_rem != 32'd0) && cmd_ready_i;
    // Fires one cycle early so the error pulse lands g_TIMEOUT cycles after the accepting edge.
    assign w_timeout = ({1'b0, r_timer} + 26'd2) >= 26'(g_TIMEOUT);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_grant_any) w_next = S_ISSUE;
            S_ISSUE: begin
                if (r_rem == 32'd0)   w_next = S_FINISH;
                else if (cmd_ready_i) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (err_i)       w_next = S_FINISH;
                else if (done_i) w_next = (r_rem != 32'd0) ? S_ISSUE : S_FINISH;
                else if (w_timeout) w_next = S_FINISH;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        job_done_o  = '0;
        job_err_o   = '0;
        for (int i = 0; i < g_CHANNELS; i++) begin
            req_ready_o[i] = (r_state == S_IDLE) && w_grant_any && !rst_i && (w_grant_ch == 3'(i));
            job_done_o[i]  = (r_state == S_FINISH) && !r_err && (r_ch == 3'(i));
            job_err_o[i]   = (r_state == S_FINISH) && r_err && (r_ch == 3'(i));
        end
    end

    assign cmd_valid_o     = (r_state == S_ISSUE) && (r_rem != 32'd0);
    assign cmd_last_o      = cmd_valid_o && (w_chunk == r_rem);
    assign cmd_host_addr_o = r_host;
    assign cmd_dev_addr_o  = r_dev;
    assign cmd_len_o       = w_chunk;
    assign cmd_dir_o       = r_dir;
    assign cmd_ch_o        = r_ch;
    assign busy_o          = (r_state != S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_host  <= '0;
            r_dev   <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
            r_ch    <= '0;
            r_last  <= 3'(g_CHANNELS - 1);
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_any) begin
                        r_host  <= req_host_addr_i[int'(w_grant_ch)*64 +: 64];
                        r_dev   <= req_dev_addr_i[int'(w_grant_ch)*32 +: 32];
                        r_rem   <= req_len_i[int'(w_grant_ch)*32 +: 32];
                        r_dir   <= req_dir_i[w_grant_ch];
                        r_ch    <= w_grant_ch;
                        r_last  <= w_grant_ch;
                        r_err   <= 1'b0;
                        r_timer <= '0;
                    end
                end
                S_ISSUE: begin
                    if (w_accept) begin
                        r_host  <= r_host + 64'(w_chunk);
                        r_dev   <= r_dev + w_chunk;
                        r_rem   <= r_rem - w_chunk;
                        r_timer <= '0;
                    end
                end
                S_WAIT: begin
                    r_timer <= r_timer + 25'd1;
                    if (err_i || (!done_i && w_timeout)) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_chunk_scheduler.sv
// Directed bench for dma_chunk_scheduler: table of chunking jobs plus
// hand-written sequences for arbitration, zero length, timeout, stalls and reset.
module tb_dma_chunk_scheduler;
    localparam int CH   = 2;
    localparam int MAXC = 4096;
    localparam int TO   = 100;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [CH-1:0]   req_valid_i, req_ready_o, req_dir_i, job_done_o, job_err_o;
    logic [64*CH-1:0] req_host_addr_i;
    logic [32*CH-1:0] req_dev_addr_i, req_len_i;
    logic            cmd_valid_o, cmd_ready_i, cmd_dir_o, cmd_last_o, done_i, err_i, busy_o;
    logic [63:0]     cmd_host_addr_o;
    logic [31:0]     cmd_dev_addr_o, cmd_len_o;
    logic [2:0]      cmd_ch_o;

    int compared   = 0;
    int mismatched = 0;

    dma_chunk_scheduler #(.g_CHANNELS(CH), .g_MAX_CHUNK(MAXC), .g_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_host_addr_i(req_host_addr_i), .req_dev_addr_i(req_dev_addr_i),
        .req_len_i(req_len_i), .req_dir_i(req_dir_i),
        .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
        .cmd_host_addr_o(cmd_host_addr_o), .cmd_dev_addr_o(cmd_dev_addr_o),
        .cmd_len_o(cmd_len_o), .cmd_dir_o(cmd_dir_o), .cmd_last_o(cmd_last_o),
        .cmd_ch_o(cmd_ch_o), .done_i(done_i), .err_i(err_i),
        .job_done_o(job_done_o), .job_err_o(job_err_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] host;
        logic [31:0] dev;
        logic [31:0] len;
        logic        dir;
        logic [31:0] expFirstLen;
        logic        expFirstLast;
        int          expChunks;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic driveReq(input int ch, input logic [63:0] host, input logic [31:0] dev,
                            input logic [31:0] len, input logic dir);
        req_host_addr_i[ch*64 +: 64] = host;
        req_dev_addr_i[ch*32 +: 32]  = dev;
        req_len_i[ch*32 +: 32]       = len;
        req_dir_i[ch]                = dir;
        req_valid_i[ch]              = 1'b1;
    endtask

    // Holds the request until granted (bounded), then drops req_valid_i after the grant edge.
    task automatic waitGrant(input int ch, input string name);
        int guard = 0;
        #1;
        while (!req_ready_o[ch] && guard < 20) begin
            tick;
            #1;
            guard++;
        end
        checkOutput({name, "_grant"}, 64'(req_ready_o[ch]), 64'd1);
        tick;
        req_valid_i[ch] = 1'b0;
    endtask

    // Runs one ch0 job with done_i 5 cycles after each accept, checking every chunk against the boundary model.
    task automatic applyStimulus(input int idx, input vec_t v, output int nChunks, output int nDone,
                                 output int nErr, output logic [31:0] firstLen, output logic firstLast);
        logic [63:0] h, expLen, span;
        logic [31:0] d, rem;
        int sinceAccept = -1;
        h = v.host; d = v.dev; rem = v.len;
        nChunks = 0; nDone = 0; nErr = 0; firstLen = '0; firstLast = 1'b0;
        cmd_ready_i = 1'b1;
        driveReq(0, v.host, v.dev, v.len, v.dir);
        waitGrant(0, $sformatf("v%0d", idx));
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (sinceAccept >= 0) sinceAccept++;
            done_i = (sinceAccept == 5);
            if (done_i) sinceAccept = -1;
            #1;
            if (cmd_valid_o) begin
                span   = 64'(MAXC) - (h % 64'(MAXC));
                expLen = (64'(rem) < span) ? 64'(rem) : span;
                if (nChunks == 0) begin
                    firstLen  = cmd_len_o;
                    firstLast = cmd_last_o;
                end
                checkOutput($sformatf("v%0d_c%0d_len", idx, nChunks), 64'(cmd_len_o), expLen);
                checkOutput($sformatf("v%0d_c%0d_host", idx, nChunks), cmd_host_addr_o, h);
                checkOutput($sformatf("v%0d_c%0d_dev", idx, nChunks), 64'(cmd_dev_addr_o), 64'(d));
                checkOutput($sformatf("v%0d_c%0d_last", idx, nChunks), 64'(cmd_last_o), 64'(expLen == 64'(rem)));
                checkOutput($sformatf("v%0d_c%0d_dir", idx, nChunks), 64'(cmd_dir_o), 64'(v.dir));
                h   = h + expLen;
                d   = d + 32'(expLen);
                rem = rem - 32'(expLen);
                nChunks++;
                sinceAccept = 0;
            end
            if (job_done_o[0]) nDone++;
            if (job_err_o[0])  nErr++;
            if (nDone + nErr > 0) break;
            tick;
        end
        done_i = 1'b0;
        tick;
        checkOutput($sformatf("v%0d_busy_after", idx), 64'(busy_o), 64'd0);
    endtask

    initial begin
        int nChunks, nDone, nErr, nG, chErr, overlap, sawCmd, doneAt, doneCnt, errAt, pulses, stableErr;
        int grants[4];
        int expGrant[4];
        int lastG;
        logic [31:0] fl;
        logic flast;

        vecs[0] = '{64'h2000_0000, 32'h100, 32'd10000, 1'b0, 32'd4096, 1'b0, 3};
        vecs[1] = '{64'h2000_0F00, 32'h0, 32'd512, 1'b0, 32'd256, 1'b0, 2};
        vecs[2] = '{64'h1000, 32'h40, 32'd100, 1'b1, 32'd100, 1'b1, 1};
        vecs[3] = '{64'h0FFF, 32'h7, 32'd1, 1'b0, 32'd1, 1'b1, 1};
        vecs[4] = '{64'h0FFF, 32'h7, 32'd2, 1'b1, 32'd1, 1'b0, 2};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFC0, 32'hFFFF_FFF0, 32'd128, 1'b0, 32'd64, 1'b0, 2};
        vecs[6] = '{64'h40, 32'h0, 32'd4096, 1'b0, 32'd4032, 1'b0, 2};
        vecs[7] = '{64'h3000, 32'h200, 32'd4096, 1'b1, 32'd4096, 1'b1, 1};
        expGrant = '{0, 1, 0, 1};

        rst_i = 1'b0; req_valid_i = '0; req_host_addr_i = '0; req_dev_addr_i = '0;
        req_len_i = '0; req_dir_i = '0; cmd_ready_i = 1'b0; done_i = 1'b0; err_i = 1'b0;
        #1 rst_i = 1'b1;

        // Outputs during reset, with requests pending
        driveReq(0, 64'h1234, 32'h10, 32'd64, 1'b1);
        driveReq(1, 64'h5678, 32'h20, 32'd64, 1'b1);
        tick; tick;
        checkOutput("rst_req_ready", 64'(req_ready_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_cmd_valid", 64'(cmd_valid_o), 64'd0);
        checkOutput("rst_cmd_len", 64'(cmd_len_o), 64'd0);
        checkOutput("rst_cmd_host", cmd_host_addr_o, 64'd0);
        checkOutput("rst_cmd_last", 64'(cmd_last_o), 64'd0);
        checkOutput("rst_cmd_dir", 64'(cmd_dir_o), 64'd0);
        checkOutput("rst_job_done", 64'(job_done_o), 64'd0);
        checkOutput("rst_job_err", 64'(job_err_o), 64'd0);

        // Round robin: both channels held valid, done_i held high
        driveReq(0, 64'h0, 32'h0, 32'd64, 1'b0);
        driveReq(1, 64'h1000, 32'h10, 32'd64, 1'b1);
        cmd_ready_i = 1'b1; done_i = 1'b1;
        rst_i = 1'b0;
        nG = 0; lastG = -1; chErr = 0; overlap = 0;
        for (int cyc = 0; cyc < 200 && nG < 4; cyc++) begin
            #1;
            if (req_ready_o != '0) begin
                if (busy_o) overlap++;
                lastG = req_ready_o[1] ? 1 : 0;
                grants[nG] = lastG;
                nG++;
            end
            if (cmd_valid_o && ((int'(cmd_ch_o) != lastG) || (cmd_dir_o != (lastG == 1)))) chErr++;
            tick;
        end
        req_valid_i = '0;
        checkOutput("rr_count", 64'(nG), 64'd4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("rr_grant%0d", i), 64'(grants[i]), 64'(expGrant[i]));
        checkOutput("rr_cmd_ch", 64'(chErr), 64'd0);
        checkOutput("rr_no_grant_busy", 64'(overlap), 64'd0);
        for (int cyc = 0; cyc < 20 && busy_o; cyc++) tick;
        done_i = 1'b0;
        checkOutput("rr_idle", 64'(busy_o), 64'd0);

        // Zero-length job on ch1
        driveReq(1, 64'h800, 32'h4, 32'd0, 1'b0);
        waitGrant(1, "len0");
        sawCmd = 0; doneAt = -1; doneCnt = 0;
        for (int k = 1; k <= 4; k++) begin
            if (cmd_valid_o) sawCmd++;
            if (job_done_o[1]) begin doneAt = k; doneCnt++; end
            tick;
        end
        checkOutput("len0_no_cmd", 64'(sawCmd), 64'd0);
        checkOutput("len0_done_at", 64'(doneAt), 64'd2);
        checkOutput("len0_done_cnt", 64'(doneCnt), 64'd1);

        // Table of chunking jobs
        for (int i = 0; i < 8; i++) begin
            applyStimulus(i, vecs[i], nChunks, nDone, nErr, fl, flast);
            checkOutput($sformatf("v%0d_chunks", i), 64'(nChunks), 64'(vecs[i].expChunks));
            checkOutput($sformatf("v%0d_first_len", i), 64'(fl), 64'(vecs[i].expFirstLen));
            checkOutput($sformatf("v%0d_first_last", i), 64'(flast), 64'(vecs[i].expFirstLast));
            checkOutput($sformatf("v%0d_done", i), 64'(nDone), 64'd1);
            checkOutput($sformatf("v%0d_err", i), 64'(nErr), 64'd0);
        end

        // Timeout: done_i never arrives
        cmd_ready_i = 1'b1;
        driveReq(0, 64'h0, 32'h0, 32'd64, 1'b0);
        waitGrant(0, "to");
        for (int k = 0; k < 10 && !cmd_valid_o; k++) tick;
        checkOutput("to_cmd_valid", 64'(cmd_valid_o), 64'd1);
        tick;
        errAt = -1; doneCnt = 0;
        for (int k = 1; k <= 300; k++) begin
            if (job_done_o != '0) doneCnt++;
            if (job_err_o[0]) begin errAt = k; break; end
            tick;
        end
        checkOutput("to_err_at", 64'(errAt), 64'd100);
        checkOutput("to_no_done", 64'(doneCnt), 64'd0);
        tick;
        checkOutput("to_busy_drop", 64'(busy_o), 64'd0);

        // done_i/err_i ignored in ISSUE; err_i beats done_i in WAIT
        cmd_ready_i = 1'b0;
        driveReq(0, 64'h100, 32'h0, 32'd64, 1'b0);
        waitGrant(0, "errdone");
        done_i = 1'b1; err_i = 1'b1;
        tick;
        done_i = 1'b0; err_i = 1'b0;
        checkOutput("ed_issue_ignored", 64'(cmd_valid_o), 64'd1);
        checkOutput("ed_no_pulse", 64'({job_err_o, job_done_o}), 64'd0);
        cmd_ready_i = 1'b1;
        tick;
        cmd_ready_i = 1'b0;
        done_i = 1'b1; err_i = 1'b1;
        tick;
        done_i = 1'b0; err_i = 1'b0;
        checkOutput("ed_job_err", 64'(job_err_o), 64'd1);
        checkOutput("ed_job_done", 64'(job_done_o), 64'd0);
        tick;
        checkOutput("ed_busy", 64'(busy_o), 64'd0);

        // cmd_ready_i stall for 20 cycles, then reset while in WAIT
        driveReq(0, 64'h2000_0F00, 32'h55, 32'd512, 1'b1);
        waitGrant(0, "hold");
        checkOutput("hold_len", 64'(cmd_len_o), 64'd256);
        stableErr = 0;
        for (int k = 0; k < 20; k++) begin
            if (!cmd_valid_o || cmd_host_addr_o != 64'h2000_0F00 || cmd_dev_addr_o != 32'h55 ||
                cmd_len_o != 32'd256 || cmd_last_o || !cmd_dir_o || cmd_ch_o != 3'd0) stableErr++;
            tick;
        end
        checkOutput("hold_stable", 64'(stableErr), 64'd0);
        cmd_ready_i = 1'b1;
        tick;
        cmd_ready_i = 1'b0;
        checkOutput("hold_wait_busy", 64'(busy_o), 64'd1);
        checkOutput("hold_wait_host", cmd_host_addr_o, 64'h2000_1000);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("midrst_busy", 64'(busy_o), 64'd0);
        checkOutput("midrst_cmd", {cmd_host_addr_o[31:0], cmd_dev_addr_o}, 64'd0);
        checkOutput("midrst_len", 64'({cmd_len_o, cmd_valid_o, cmd_last_o, cmd_dir_o}), 64'd0);
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) rst_i = 1'b0;
            done_i = (k == 3);
            #1;
            if ((job_done_o | job_err_o) != '0) pulses++;
            tick;
        end
        done_i = 1'b0;
        checkOutput("midrst_no_pulse", 64'(pulses), 64'd0);
        checkOutput("midrst_idle", 64'(busy_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
